handshake_rx_multi: RTL and testbench
=====================================

# handshake_rx_multi

Multi-channel receive side of a 4-phase req/ack handshake. It synchronises NUM_CH asynchronous request lines into the local clock domain and captures each channel's data word. Captured words are merged through a round-robin arbiter onto one valid/ready output stream, and each source is acknowledged only once its word has been accepted. It sits at the boundary of the destination clock domain, one instance per group of source-domain senders.

## Interface
Parameters:
- DATA_W, 8, data word width per channel
- NUM_CH, 4, number of handshake channels (1..16)
- SYNC_STAGES, 2, synchroniser flops per req line (>=2)
- CH_W, derived: $clog2(NUM_CH), minimum 1

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- req_in  in  NUM_CH  asynchronous requests; bit i belongs to channel i
- data_in  in  NUM_CH*DATA_W  channel i data at bits [i*DATA_W +: DATA_W]; held stable by the source while req_in[i] is high
- ack_out  out  NUM_CH  acknowledge back to each source
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts the word
- out_data  out  DATA_W  output word
- out_ch  out  CH_W  channel index of out_data
- err  out  NUM_CH  sticky protocol-error flags (see Configuration)

## Operation
- Each req_in[i] passes through SYNC_STAGES flops, giving req_s[i]. No other input is synchronised.
- Per-channel FSM, states IDLE, HOLD and ACK:
  - IDLE, ack=0: if req_s=1, load hold[i]<=data_in[i] and go to HOLD.
  - HOLD, ack=0, channel pending: when granted, go to ACK and set ack_out[i]<=1 on the same edge.
  - ACK, ack=1: if req_s=0, set ack_out[i]<=0 and go to IDLE.
- Output stage is one register deep. load = !out_valid || out_ready.
  - On a load edge with any channel in HOLD: grant the first HOLD channel searching from last+1 upward with wrap. Then out_data<=hold, out_ch<=index, out_valid<=1, last<=index.
  - On a load edge with no HOLD channel: out_valid<=0.
- While out_valid=1 and out_ready=0: out_data and out_ch stay unchanged, no grant is issued, and HOLD channels wait.
- A channel is never granted twice per handshake. A new capture requires ACK->IDLE, which requires req_s to go low.

## Timing
- Reset values: ack_out=0, out_valid=0, out_data=0, out_ch=0, err=0, synchronisers=0, all FSMs IDLE, last=NUM_CH-1 so channel 0 has first priority.
- Rising edges are counted from the first edge at which req_in[i]=1 is sampled (edge 1). With an idle output and no contention:
  - Synchroniser fills on edges 1..SYNC_STAGES.
  - Capture on edge SYNC_STAGES+1.
  - out_valid=1 and ack_out[i]=1 after edge SYNC_STAGES+2.
- Falling req_in sampled at edge 1: ack_out[i]=0 after edge SYNC_STAGES+1. The minimum full handshake cycle is about 2*(SYNC_STAGES+2) clocks plus the source-side latency.
- Back-to-back output: with out_ready held at 1 and several channels in HOLD, one word per clock.
- Simultaneous requests on all channels produce grants in order 0,1,..,NUM_CH-1 on consecutive load edges.
- Reset mid-operation returns the block to its reset values and drops any captured word. If req_in is still high after reset, the word is re-captured and re-delivered. The source protocol tolerates this.

## Configuration
- HANDSHAKE_RX_ERR_EN defined:
  - A channel in HOLD that sees req_s=0 sets err[i]<=1. The flag is sticky and cleared only by rst.
  - The captured word is still delivered, and the FSM proceeds normally to ACK then IDLE.
- HANDSHAKE_RX_ERR_EN undefined: err is tied to 0 and no detection logic is built.

## Test plan
- Single transfer, SYNC_STAGES=2: req_in[0]=1 with data 8'hA5, out_ready=1 -> out_valid and ack_out[0] high after edge 4, out_data=8'hA5, out_ch=0. req_in[0]=0 -> ack_out[0] low 3 edges later.
- Contention: all 4 req high same cycle, data 8'h10,8'h21,8'h32,8'h43, out_ready=1 -> 4 consecutive words with out_ch 0,1,2,3 and each ack_out rising with its grant.
- Backpressure: out_ready=0 for 10 cycles with ch1 and ch2 pending -> out_data stable, ack_out[2]=0 until the first accept, then ch2 delivered on the next edge.
- Fairness: ch0 re-requests continuously while ch3 is pending -> ch3 is granted before ch0's second word.
- Reset mid-handshake: rst pulsed with ch1 in ACK -> all outputs at reset values the next cycle. req_in[1] still high -> 8'h21 delivered again.
- With HANDSHAKE_RX_ERR_EN, out_ready=0 and req_in[2] dropped while in HOLD -> err[2]=1 and stays set. Without the macro -> err stays 0.

Source files
------------

// File: rtl/handshake_rx_multi.sv
// handshake_rx_multi
//   Receive side of a multi-channel 4-phase req/ack handshake. Each request
//   line is synchronised, each channel captures its data word into a holding
//   register, and a round-robin arbiter merges the captured words onto a
//   single valid/ready stream. A source is acknowledged on the edge its word
//   enters the output register, and the ack is released once its synchronised
//   request falls.
//
//   Optional feature macro: HANDSHAKE_RX_ERR_EN
//     defined   : sticky err[i] when channel i sees its request drop while its
//                 word is still waiting for a grant (word still delivered).
//     undefined : err is tied to 0 and no detection logic is built.
//
//   Ports
//     clk        clock
//     rst        synchronous active-high reset
//     req_in     [NUM_CH]          asynchronous requests, one per channel
//     data_in    [NUM_CH*DATA_W]   channel i at [i*DATA_W +: DATA_W]
//     ack_out    [NUM_CH]          acknowledge to each source
//     out_valid  output word valid
//     out_ready  downstream accepts the word
//     out_data   [DATA_W]          output word
//     out_ch     [CH_W]            channel index of out_data
//     err        [NUM_CH]          sticky protocol-error flags

// Per-channel capture FSM: IDLE -> HOLD on synchronised request, HOLD -> ACK
// on grant, ACK -> IDLE once the request has been withdrawn.
module handshake_rx_ch #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_s,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_grant,
  output logic              o_pend,
  output logic              o_ack,
  output logic [DATA_W-1:0] o_hold,
  output logic              o_err
);
  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_ACK} state_t;

  state_t            r_state, w_next;
  logic [DATA_W-1:0] r_hold;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_req_s)  w_next = S_HOLD;
      S_HOLD:  if (i_grant)  w_next = S_ACK;
      S_ACK:   if (!i_req_s) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ack is a pure decode of the state register, so it rises on the grant edge
  // and falls on the ACK->IDLE edge without a separate flop.
  always_comb begin
    o_pend = (r_state == S_HOLD);
    o_ack  = (r_state == S_ACK);
  end

  // data_in is stable while req is high, so it is safe to sample it on the
  // edge the synchronised request is first seen.
  always_ff @(posedge clk) begin
    if (rst)                                r_hold <= '0;
    else if (r_state == S_IDLE && i_req_s)  r_hold <= i_data;
  end
  assign o_hold = r_hold;

`ifdef HANDSHAKE_RX_ERR_EN
  logic r_err;
  always_ff @(posedge clk) begin
    if (rst)                                r_err <= 1'b0;
    else if (r_state == S_HOLD && !i_req_s) r_err <= 1'b1;
  end
  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif
endmodule

module handshake_rx_multi #(
  parameter int DATA_W      = 8,
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req_in,
  input  logic [NUM_CH*DATA_W-1:0] data_in,
  output logic [NUM_CH-1:0]        ack_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  output logic [NUM_CH-1:0]        err
);
  logic [NUM_CH-1:0][SYNC_STAGES-1:0] r_sync;
  logic [NUM_CH-1:0]                  w_req_s;
  logic [NUM_CH-1:0]                  w_pend;
  logic [NUM_CH-1:0]                  w_grant;
  logic [NUM_CH-1:0][DATA_W-1:0]      w_hold;

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [CH_W-1:0]   r_ch;
  logic [CH_W-1:0]   r_last;

  logic              w_load;
  logic              w_any;
  logic [CH_W-1:0]   w_gidx;

  // Request synchronisers; bit 0 is the first flop.
  always_ff @(posedge clk) begin
    if (rst) r_sync <= '0;
    else
      for (int i = 0; i < NUM_CH; i++)
        r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], req_in[i]};
  end

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_ch
      assign w_req_s[g] = r_sync[g][SYNC_STAGES-1];
      assign w_grant[g] = w_load && w_any && (w_gidx == CH_W'(g));

      handshake_rx_ch #(.DATA_W(DATA_W)) u_ch (
        .clk     (clk),
        .rst     (rst),
        .i_req_s (w_req_s[g]),
        .i_data  (data_in[g*DATA_W +: DATA_W]),
        .i_grant (w_grant[g]),
        .o_pend  (w_pend[g]),
        .o_ack   (ack_out[g]),
        .o_hold  (w_hold[g]),
        .o_err   (err[g])
      );
    end
  endgenerate

  assign w_load = !r_valid || out_ready;

  // Round-robin: first pending channel searching from last+1 upward with wrap.
  // last itself is checked last, so a channel cannot win twice in a row while
  // others wait.
  always_comb begin
    int j;
    w_any  = 1'b0;
    w_gidx = '0;
    j      = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      j = int'(r_last) + k;
      if (j >= NUM_CH) j = j - NUM_CH;
      if (!w_any && w_pend[j]) begin
        w_any  = 1'b1;
        w_gidx = CH_W'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ch    <= '0;
      r_last  <= CH_W'(NUM_CH - 1);
    end else if (w_load) begin
      if (w_any) begin
        r_valid <= 1'b1;
        r_data  <= w_hold[w_gidx];
        r_ch    <= w_gidx;
        r_last  <= w_gidx;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_ch    = r_ch;
endmodule

// File: tb/tb_handshake_rx_multi.sv
module tb_handshake_rx_multi;
  localparam int DATA_W = 8;
  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_CH-1:0]        req_in;
  logic [NUM_CH*DATA_W-1:0] data_in;
  logic [NUM_CH-1:0]        ack_out;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W-1:0]        out_data;
  logic [CH_W-1:0]          out_ch;
  logic [NUM_CH-1:0]        err;

  int n_chk  = 0;
  int n_fail = 0;
  logic [15:0] sb[$];  // {channel, data}

  handshake_rx_multi #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .data_in(data_in), .ack_out(ack_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // step n rising edges, then settle 1 time unit past the last edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int ch, input logic [7:0] d);
    sb.push_back({8'(ch), d});
  endtask

  task automatic set_ch(input int ch, input logic r, input logic [7:0] d);
    req_in[ch]           = r;
    data_in[ch*8 +: 8]   = d;
  endtask

  // Accepted words are checked against the scoreboard at the falling edge,
  // where out_valid/out_ready describe the transfer taken on the next edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) chk("sb_underflow", 32'(out_data), 32'hFFFF);
      else begin
        logic [15:0] e;
        e = sb.pop_front();
        chk("out_ch", 32'(out_ch), 32'(e[15:8]));
        chk("out_data", 32'(out_data), 32'(e[7:0]));
      end
    end
  end

  initial begin
    logic [3:0] err_exp;
`ifdef HANDSHAKE_RX_ERR_EN
    err_exp = 4'b0100;
`else
    err_exp = 4'b0000;
`endif
    rst = 1'b1; req_in = '0; data_in = '0; out_ready = 1'b1;
    tick(3);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ack",   32'(ack_out), 0);
    chk("rst_data",  32'(out_data), 0);
    chk("rst_ch",    32'(out_ch), 0);
    chk("rst_err",   32'(err), 0);
    rst = 1'b0;
    tick(1);

    // Contention: all channels at once, delivered 0..3 on consecutive edges.
    set_ch(0, 1, 8'h10); set_ch(1, 1, 8'h21); set_ch(2, 1, 8'h32); set_ch(3, 1, 8'h43);
    for (int c = 0; c < 4; c++) push(c, 8'h10 + 8'(c * 17));
    tick(3);
    chk("cont_pre_valid", 32'(out_valid), 0);
    for (int c = 0; c < 4; c++) begin
      tick(1);
      chk("cont_ch",  32'(out_ch), 32'(c));
      chk("cont_ack", 32'(ack_out), 32'((1 << (c + 1)) - 1));
    end
    req_in = '0;
    tick(4);
    chk("cont_ack_drop", 32'(ack_out), 0);
    chk("cont_idle", 32'(out_valid), 0);

    // Fairness: ch0 re-requests while ch3 waits; ch3 must win next.
    set_ch(0, 1, 8'h50); push(0, 8'h50);
    tick(4);
    chk("fair_first", 32'(out_data), 32'h50);
    out_ready = 1'b0;
    req_in[0] = 1'b0;
    set_ch(3, 1, 8'h63);
    tick(3);
    chk("fair_ack0_low", 32'(ack_out[0]), 0);
    set_ch(0, 1, 8'h51);
    tick(4);
    chk("fair_stall", 32'(out_data), 32'h50);
    push(3, 8'h63); push(0, 8'h51);
    out_ready = 1'b1;
    tick(1);
    chk("fair_ch3", 32'(out_ch), 3);
    tick(1);
    chk("fair_ch0", 32'(out_ch), 0);
    req_in = '0;
    tick(6);

    // Single transfer latency.
    set_ch(0, 1, 8'hA5); push(0, 8'hA5);
    tick(3);
    chk("single_e3_valid", 32'(out_valid), 0);
    chk("single_e3_ack",   32'(ack_out[0]), 0);
    tick(1);
    chk("single_e4_valid", 32'(out_valid), 1);
    chk("single_e4_ack",   32'(ack_out[0]), 1);
    chk("single_e4_data",  32'(out_data), 32'hA5);
    chk("single_e4_ch",    32'(out_ch), 0);
    req_in[0] = 1'b0;
    tick(2);
    chk("single_ack_hold", 32'(ack_out[0]), 1);
    tick(1);
    chk("single_ack_low",  32'(ack_out[0]), 0);
    tick(3);

    // Backpressure: ch1 stalls in the output register, ch2 waits unacked.
    out_ready = 1'b0;
    set_ch(1, 1, 8'h21); set_ch(2, 1, 8'h32);
    push(1, 8'h21); push(2, 8'h32);
    tick(4);
    chk("bp_first_ch", 32'(out_ch), 1);
    for (int c = 0; c < 10; c++) begin
      tick(1);
      chk("bp_data_stable", 32'(out_data), 32'h21);
      chk("bp_ack2_low",    32'(ack_out[2]), 0);
    end
    out_ready = 1'b1;
    tick(1);
    chk("bp_ch2",   32'(out_ch), 2);
    chk("bp_data2", 32'(out_data), 32'h32);
    chk("bp_ack2",  32'(ack_out[2]), 1);
    req_in = '0;
    tick(6);

    // Reset with ch1 in ACK; the still-high request is re-delivered.
    set_ch(1, 1, 8'h21); push(1, 8'h21);
    tick(5);
    chk("rmid_ack1", 32'(ack_out[1]), 1);
    rst = 1'b1;
    tick(1);
    chk("rmid_ack",   32'(ack_out), 0);
    chk("rmid_valid", 32'(out_valid), 0);
    chk("rmid_data",  32'(out_data), 0);
    chk("rmid_ch",    32'(out_ch), 0);
    rst = 1'b0;
    push(1, 8'h21);
    tick(4);
    chk("rmid_redeliver_valid", 32'(out_valid), 1);
    chk("rmid_redeliver_data",  32'(out_data), 32'h21);
    req_in = '0;
    tick(6);

    // Request dropped while waiting in HOLD.
    out_ready = 1'b0;
    set_ch(3, 1, 8'h43);
    tick(2);
    set_ch(2, 1, 8'h32);
    tick(6);
    chk("err_stall_ch", 32'(out_ch), 3);
    chk("err_ack2_low", 32'(ack_out[2]), 0);
    req_in[2] = 1'b0;
    tick(4);
    chk("err_set", 32'(err), 32'(err_exp));
    push(3, 8'h43); push(2, 8'h32);
    out_ready = 1'b1;
    tick(1);
    chk("err_deliver_ch", 32'(out_ch), 2);
    tick(3);
    chk("err_sticky", 32'(err), 32'(err_exp));
    req_in = '0;
    tick(6);
    chk("err_end_ack", 32'(ack_out), 0);

    chk("sb_empty", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
